// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdc_pkg
// Purpose  : Shared filter-FSM encodings and a constant clog2 for sizing.
// Revision : 1.0
// ============================================================================
package cdc_pkg;

    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_RISE_CHK = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_FALL_CHK = 2'd3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_glitch_filter.sv
`default_nettype none
// ============================================================================
// Module   : cdc_glitch_filter
// Purpose  : Four-state qualifier; level changes only after FILT_LEN equal samples.
// Revision : 1.0
// ============================================================================
module cdc_glitch_filter
    import cdc_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sample,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_glitch
);

    localparam int             CW       = (clog2(FILT_LEN) < 1) ? 1 : clog2(FILT_LEN);
    localparam logic [CW-1:0]  c_last   = CW'(FILT_LEN - 1);
    localparam logic [CW-1:0]  c_one    = CW'(1);
    localparam bit             c_direct = (FILT_LEN == 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic          r_glitch;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_LOW;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 1'b0;
            case (r_state)
                S_LOW: begin
                    if (i_sample) begin
                        if (c_direct) begin
                            r_state <= S_HIGH;
                            r_level <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_state <= S_RISE_CHK;
                            r_cnt   <= c_one;
                        end
                    end
                end
                S_RISE_CHK: begin
                    if (!i_sample) begin
                        r_state  <= S_LOW;
                        r_glitch <= 1'b1;
                    end else if (r_cnt == c_last) begin
                        r_state <= S_HIGH;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                S_HIGH: begin
                    if (!i_sample) begin
                        if (c_direct) begin
                            r_state <= S_LOW;
                            r_level <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_state <= S_FALL_CHK;
                            r_cnt   <= c_one;
                        end
                    end
                end
                default: begin
                    if (i_sample) begin
                        r_state  <= S_HIGH;
                        r_glitch <= 1'b1;
                    end else if (r_cnt == c_last) begin
                        r_state <= S_LOW;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
            endcase
        end
    end

    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_glitch = r_glitch;

endmodule
`default_nettype wire

// File: rtl/cdc_edge_event.sv
`default_nettype none
// ============================================================================
// Module   : cdc_edge_event
// Purpose  : Glitch-filtered edge detector with a rise-event queue and counters.
//            CDC_EDGE_SYNC_EN adds a two-flop synchronizer ahead of the filter.
// Revision : 1.0
// ============================================================================
module cdc_edge_event
    import cdc_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter int PEND_W   = 3,
    parameter int CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_level,
    input  logic              i_clr,
    input  logic              i_evt_ready,
    output logic              o_level,
    output logic              o_rise,
    output logic              o_fall,
    output logic              o_glitch,
    output logic              o_evt_valid,
    output logic [PEND_W-1:0] o_pend,
    output logic [CNT_W-1:0]  o_evt_cnt,
    output logic              o_ovf
);

    localparam logic [PEND_W-1:0] c_pend_max = '1;
    localparam logic [PEND_W-1:0] c_pend_one = PEND_W'(1);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);

    logic w_sample;

`ifdef CDC_EDGE_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_level};
        end
    end

    assign w_sample = r_sync[1];
`else
    assign w_sample = i_level;
`endif

    cdc_glitch_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_sample (w_sample),
        .o_level  (o_level),
        .o_rise   (o_rise),
        .o_fall   (o_fall),
        .o_glitch (o_glitch)
    );

    logic              w_inc;
    logic              w_acc;
    logic [PEND_W-1:0] r_pend;
    logic              r_evt_valid;
    logic [CNT_W-1:0]  r_evt_cnt;
    logic              r_ovf;

    assign w_inc = o_rise;
    assign w_acc = r_evt_valid & i_evt_ready;

    // Valid tracks pend != 0 by construction, so it is updated alongside pend.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_pend      <= '0;
            r_evt_valid <= 1'b0;
            r_evt_cnt   <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_inc && !w_acc) begin
                if (r_pend == c_pend_max) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_pend      <= r_pend + c_pend_one;
                    r_evt_valid <= 1'b1;
                end
            end else if (w_acc && !w_inc) begin
                r_pend      <= r_pend - c_pend_one;
                r_evt_valid <= (r_pend != c_pend_one);
            end
            if (w_inc && (r_evt_cnt != c_cnt_max)) begin
                r_evt_cnt <= r_evt_cnt + c_cnt_one;
            end
        end
    end

    assign o_pend      = r_pend;
    assign o_evt_valid = r_evt_valid;
    assign o_evt_cnt   = r_evt_cnt;
    assign o_ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cdc_edge_event.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_edge_event
// Purpose  : Self-checking bench for cdc_edge_event against a run-length model.
// Revision : 1.0
// ============================================================================
module tb_cdc_edge_event;

    localparam int FILT_LEN = 4;
    localparam int PEND_W   = 3;
    localparam int CNT_W    = 16;
`ifdef CDC_EDGE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT      = FILT_LEN + SYNC;
    localparam int PEND_MAX = (1 << PEND_W) - 1;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              lvl = 1'b0;
    logic              clr = 1'b0;
    logic              ready = 1'b0;
    logic              o_level, o_rise, o_fall, o_glitch, o_evt_valid, o_ovf;
    logic [PEND_W-1:0] o_pend;
    logic [CNT_W-1:0]  o_evt_cnt;

    always #5 clk = ~clk;

    cdc_edge_event #(
        .FILT_LEN (FILT_LEN),
        .PEND_W   (PEND_W),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_level     (lvl),
        .i_clr       (clr),
        .i_evt_ready (ready),
        .o_level     (o_level),
        .o_rise      (o_rise),
        .o_fall      (o_fall),
        .o_glitch    (o_glitch),
        .o_evt_valid (o_evt_valid),
        .o_pend      (o_pend),
        .o_evt_cnt   (o_evt_cnt),
        .o_ovf       (o_ovf)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: filtered level plus length of the current opposing run.
    int m_level, m_rise, m_fall, m_glitch, m_run;
    int m_pend, m_cnt, m_ovf;
    int s1, s2;
    int n_rise_seen, n_glitch_seen;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_level = 0; m_rise = 0; m_fall = 0; m_glitch = 0; m_run = 0;
        m_pend = 0; m_cnt = 0; m_ovf = 0; s1 = 0; s2 = 0;
    endtask

    task automatic model_update();
        int smp;
        bit inc, acc;
        if (rst) begin
            model_reset();
            return;
        end
        inc = (m_rise != 0);
        acc = (m_pend != 0) && ready;
        if (clr) begin
            m_pend = 0; m_cnt = 0; m_ovf = 0;
        end else begin
            if (inc && !acc) begin
                if (m_pend == PEND_MAX) m_ovf = 1;
                else m_pend++;
            end else if (acc && !inc) begin
                m_pend--;
            end
            if (inc && m_cnt < CNT_MAX) m_cnt++;
        end
        smp = (SYNC != 0) ? s2 : int'(lvl);
        s2 = s1;
        s1 = int'(lvl);
        m_rise = 0; m_fall = 0; m_glitch = 0;
        if (smp != m_level) begin
            m_run++;
            if (m_run == FILT_LEN) begin
                m_level = smp;
                if (smp != 0) m_rise = 1;
                else m_fall = 1;
                m_run = 0;
            end
        end else begin
            if (m_run > 0) m_glitch = 1;
            m_run = 0;
        end
    endtask

    task automatic compare_all();
        check("level", int'(o_level), m_level);
        check("rise", int'(o_rise), m_rise);
        check("fall", int'(o_fall), m_fall);
        check("glitch", int'(o_glitch), m_glitch);
        check("pend", int'(o_pend), m_pend);
        check("evt_valid", int'(o_evt_valid), (m_pend != 0) ? 1 : 0);
        check("evt_cnt", int'(o_evt_cnt), m_cnt);
        check("ovf", int'(o_ovf), m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        n_rise_seen   += int'(o_rise);
        n_glitch_seen += int'(o_glitch);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_rise(input string name);
        int n;
        n = 0;
        while (m_rise == 0 && n < 4 * LAT + 10) begin
            step();
            n++;
        end
        if (m_rise == 0) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic pulse_rise();
        lvl = 1'b1; steps(LAT + 2);
        lvl = 1'b0; steps(LAT + 2);
    endtask

    initial begin
        int n;
        model_reset();

        // Reset state
        rst = 1'b1; lvl = 1'b0;
        steps(2);
        check("rst_level", int'(o_level), 0);
        check("rst_pend", int'(o_pend), 0);
        check("rst_cnt", int'(o_evt_cnt), 0);
        check("rst_ovf", int'(o_ovf), 0);
        rst = 1'b0;

        // Clean rise: pulse after LAT edges, event visible one cycle later
        lvl = 1'b1;
        n_rise_seen = 0;
        steps(LAT - 1);
        check("rise_early", int'(o_rise), 0);
        step();
        check("rise_at_lat", int'(o_rise), 1);
        check("model_rise_at_lat", m_rise, 1);
        check("level_at_lat", int'(o_level), 1);
        step();
        check("rise_one_cycle", int'(o_rise), 0);
        check("pend_after_rise", int'(o_pend), 1);
        check("valid_after_rise", int'(o_evt_valid), 1);
        steps(8);
        check("single_rise", n_rise_seen, 1);

        // Short high burst is rejected
        rst = 1'b1; lvl = 1'b0; step(); rst = 1'b0;
        steps(3);
        n_rise_seen = 0; n_glitch_seen = 0;
        lvl = 1'b1; steps(FILT_LEN - 1);
        lvl = 1'b0; steps(10);
        check("glitch_once", n_glitch_seen, 1);
        check("glitch_no_rise", n_rise_seen, 0);
        check("glitch_level", int'(o_level), 0);
        check("glitch_pend", int'(o_pend), 0);
        check("glitch_cnt", int'(o_evt_cnt), 0);

        // Pending saturation and overflow
        ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pulse_rise();
            if (i == 6) check("ovf_after_7", int'(o_ovf), 0);
            if (i == 7) check("ovf_after_8", int'(o_ovf), 1);
        end
        check("sat_pend", int'(o_pend), 7);
        check("sat_cnt", int'(o_evt_cnt), 9);
        check("sat_valid", int'(o_evt_valid), 1);

        // Clear coinciding with a rise pulse
        lvl = 1'b1;
        wait_rise("clr_rise");
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_cnt", int'(o_evt_cnt), 0);
        check("clr_pend", int'(o_pend), 0);
        check("clr_ovf", int'(o_ovf), 0);
        check("clr_level", int'(o_level), 1);

        // Rise and accept together leave pend unchanged
        lvl = 1'b0; steps(LAT + 2);
        pulse_rise(); pulse_rise();
        check("pend_two", int'(o_pend), 2);
        lvl = 1'b1;
        wait_rise("coinc_rise");
        ready = 1'b1; step();
        check("coinc_pend", int'(o_pend), 2);
        step();
        check("drain_1", int'(o_pend), 1);
        step();
        check("drain_0", int'(o_pend), 0);
        check("drain_valid", int'(o_evt_valid), 0);
        step();
        check("ready_idle", int'(o_pend), 0);
        ready = 1'b0;

        // Reset mid-qualification, then a full re-qualification
        lvl = 1'b0; steps(LAT + 2);
        lvl = 1'b1; steps(2);
        rst = 1'b1; step();
        check("midrst_level", int'(o_level), 0);
        check("midrst_rise", int'(o_rise), 0);
        check("midrst_glitch", int'(o_glitch), 0);
        check("midrst_cnt", int'(o_evt_cnt), 0);
        rst = 1'b0;
        n = 0;
        while (o_rise !== 1'b1 && n < 4 * LAT + 10) begin
            step();
            n++;
        end
        check("midrst_latency", n, LAT);

        // Randomized traffic
        for (int blk = 0; blk < 600; blk++) begin
            int run;
            lvl = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 2 * FILT_LEN + 2);
            for (int c = 0; c < run; c++) begin
                ready = ($urandom_range(0, 3) == 0);
                clr   = ($urandom_range(0, 63) == 0);
                rst   = ($urandom_range(0, 499) == 0);
                step();
            end
        end
        rst = 1'b0; clr = 1'b0; ready = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
